// File: rtl/hurricane_ctrl_if.sv
// hurricane_ctrl_if
//   Signal bundle between mode_fsm-side logic and the hurricane sequencer.
//   slave  : the sequencer (hurricane_ctrl) - consumes machine/mode/menu,
//            produces grant, return target, countdown and done pulse.
//   master : the environment driving the sequencer inputs.
//   machine_state          1 = hood powered on
//   mode_state       [2:0] current mode from mode_fsm (3'b011 = hurricane)
//   menu_btn               debounced menu button, level
//   hurricane_mode_enabled 1 = mode 3 entry allowed / may continue
//   return_state           valid while enabled=0: 1 = mode 2, 0 = standby
//   countdown_sec    [7:0] seconds remaining in RUN/RETURN, else 0
//   countdown_active       1 while RUN or RETURN
//   hurricane_done         one-cycle pulse on entry to LOCKED
interface hurricane_ctrl_if;
    logic       machine_state;
    logic [2:0] mode_state;
    logic       menu_btn;
    logic       hurricane_mode_enabled;
    logic       return_state;
    logic [7:0] countdown_sec;
    logic       countdown_active;
    logic       hurricane_done;

    modport master (
        output machine_state, mode_state, menu_btn,
        input  hurricane_mode_enabled, return_state, countdown_sec,
               countdown_active, hurricane_done
    );

    modport slave (
        input  machine_state, mode_state, menu_btn,
        output hurricane_mode_enabled, return_state, countdown_sec,
               countdown_active, hurricane_done
    );
endinterface

// File: rtl/hurricane_ctrl.sv
// hurricane_ctrl
//   Grants hurricane mode (mode 3) once per power-on, times the mode 3 run,
//   and times the return countdown after a menu press. On expiry the grant
//   is withdrawn and return_state tells mode_fsm where to drop.
// Ports
//   clk  system clock
//   rst  asynchronous reset, active-low
//   bus  hurricane_ctrl_if.slave (see interface file for signal list)
// Parameters
//   TICK_DIV    clk cycles per second tick
//   RUN_SEC     seconds mode 3 may run before forced exit to standby (1..255)
//   RETURN_SEC  seconds from menu press to exit into mode 2 (1..255)
module hurricane_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned RUN_SEC    = 60,
    parameter int unsigned RETURN_SEC = 60
) (
    input  logic            clk,
    input  logic            rst,
    hurricane_ctrl_if.slave bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]    RUN_LOAD  = 8'(RUN_SEC);
    localparam logic [7:0]    RET_LOAD  = 8'(RETURN_SEC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RETURN,
        ST_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    count_q, count_d;
    logic          menu_prev_q;
    logic          enabled_q, enabled_d;
    logic          ret_q, ret_d;
    logic          active_q, active_d;
    logic          done_q, done_d;

    logic menu_edge;
    logic mode_is_h;
    logic sec_tick;

    assign menu_edge = bus.menu_btn & ~menu_prev_q;
    assign mode_is_h = (bus.mode_state == 3'b011);
    // Prescaler only runs in RUN/RETURN and is zero elsewhere, so a wrap
    // value here can only be reached while counting.
    assign sec_tick  = (presc_q == PRESC_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            count_q     <= '0;
            menu_prev_q <= 1'b0;
            enabled_q   <= 1'b1;
            ret_q       <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            count_q     <= count_d;
            menu_prev_q <= bus.menu_btn;
            enabled_q   <= enabled_d;
            ret_q       <= ret_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        enabled_d = enabled_q;
        ret_d     = ret_q;
        active_d  = active_q;
        done_d    = 1'b0;

        if (!bus.machine_state) begin
            // Power-off is the only way out of LOCKED; no done pulse here.
            state_d   = ST_IDLE;
            presc_d   = '0;
            count_d   = '0;
            enabled_d = 1'b1;
            ret_d     = 1'b0;
            active_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    enabled_d = 1'b1;
                    count_d   = '0;
                    active_d  = 1'b0;
                    presc_d   = '0;
                    if (mode_is_h) begin
                        state_d  = ST_RUN;
                        count_d  = RUN_LOAD;
                        active_d = 1'b1;
                    end
                end
                ST_RUN, ST_RETURN: begin
                    presc_d = sec_tick ? '0 : presc_q + 1'b1;
                    if (!mode_is_h || (sec_tick && count_q <= 8'd1)) begin
                        // Expiry outranks a coincident menu edge; leaving
                        // mode 3 early also consumes the grant.
                        state_d   = ST_LOCKED;
                        presc_d   = '0;
                        count_d   = '0;
                        enabled_d = 1'b0;
                        active_d  = 1'b0;
                        done_d    = 1'b1;
                        ret_d     = mode_is_h && (state_q == ST_RETURN);
                    end else begin
                        if (sec_tick) begin
                            count_d = count_q - 8'd1;
                        end
                        if (state_q == ST_RUN && menu_edge) begin
                            state_d = ST_RETURN;
                            count_d = RET_LOAD;
                            presc_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    enabled_d = 1'b0;
                    count_d   = '0;
                    active_d  = 1'b0;
                    presc_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hurricane_mode_enabled = enabled_q;
    assign bus.return_state           = ret_q;
    assign bus.countdown_sec          = count_q;
    assign bus.countdown_active       = active_q;
    assign bus.hurricane_done         = done_q;

endmodule

// File: tb/tb_hurricane_ctrl.sv
// tb_hurricane_ctrl
//   Directed bench for hurricane_ctrl with TICK_DIV=4, RUN_SEC=3,
//   RETURN_SEC=2. Stimulus pushes cycle-stamped expected outputs and
//   expected done pulses into queues; a negedge monitor pops and compares.
module tb_hurricane_ctrl;

    logic clk;
    logic rst;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    hurricane_ctrl_if bus ();

    hurricane_ctrl #(
        .TICK_DIV   (4),
        .RUN_SEC    (3),
        .RETURN_SEC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic       en;
        logic       ret;
        logic       act;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    logic done_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int k, input string name, input logic en,
                             input logic ret, input logic act,
                             input logic [7:0] cnt, input logic done);
        exp_t e;
        e.cyc  = cyc + k;
        e.name = name;
        e.en   = en;
        e.ret  = ret;
        e.act  = act;
        e.cnt  = cnt;
        e.done = done;
        exp_q.push_back(e);
        if (done) done_q.push_back(ret);
    endtask

    // Monitor: timed output checks plus a check on every done pulse.
    always @(negedge clk) begin
        logic [11:0] got;
        logic [11:0] req;
        logic        r;
        got = {bus.hurricane_mode_enabled, bus.return_state,
               bus.countdown_active, bus.hurricane_done, bus.countdown_sec};
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                req = {exp_q[i].en, exp_q[i].ret, exp_q[i].act,
                       exp_q[i].done, exp_q[i].cnt};
                checks++;
                if (exp_q[i].cyc != cyc || got !== req) begin
                    errors++;
                    $display("FAIL %s cyc=%0d en/ret/act/done/cnt got=%b_%b_%b_%b_%0d required=%b_%b_%b_%b_%0d",
                             exp_q[i].name, cyc, got[11], got[10], got[9],
                             got[8], got[7:0], req[11], req[10], req[9],
                             req[8], req[7:0]);
                end
                exp_q.delete(i);
            end
        end
        if (bus.hurricane_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d got done=1 required none", cyc);
            end else begin
                r = done_q.pop_front();
                if (bus.return_state !== r || bus.hurricane_mode_enabled !== 1'b0) begin
                    errors++;
                    $display("FAIL done_event cyc=%0d got ret=%b en=%b required ret=%b en=0",
                             cyc, bus.return_state, bus.hurricane_mode_enabled, r);
                end
            end
        end
    end

    // Power off for one edge, then power back on with mode 3 presented.
    // Returns right after machine_state rises; RUN is loaded one edge later.
    task automatic power_cycle(input string tag);
        bus.machine_state = 1'b0;
        expect_at(1, {tag, "_poweroff_idle"}, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(1);
        bus.machine_state = 1'b1;
        bus.mode_state    = 3'b011;
        expect_at(1, {tag, "_regrant"}, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got timeout required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        bus.machine_state = 1'b0;
        bus.mode_state    = 3'b000;
        bus.menu_btn      = 1'b0;

        step(2);
        expect_at(0, "reset_state", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(1);
        rst = 1'b1;
        step(1);

        // Plain run to expiry: 3,2,1 every 4 clk, lock 12 clk after entry.
        bus.machine_state = 1'b1;
        bus.mode_state    = 3'b011;
        expect_at(1,  "run_entry",  1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
        expect_at(4,  "run_hold3",  1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
        expect_at(5,  "run_cnt2",   1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
        expect_at(9,  "run_cnt1",   1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
        expect_at(12, "run_last",   1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
        expect_at(13, "run_expire", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        expect_at(14, "run_locked", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step(15);

        // Re-presenting mode 3 in LOCKED must not re-grant.
        bus.mode_state = 3'b000;
        step(2);
        bus.mode_state = 3'b011;
        expect_at(3, "locked_no_regrant", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4);

        // Single menu press at count=2 -> RETURN from 2, exit to mode 2.
        power_cycle("menu");
        step(5);
        bus.menu_btn = 1'b1;
        expect_at(1,  "ret_entry",  1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
        expect_at(4,  "ret_hold2",  1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
        expect_at(5,  "ret_cnt1",   1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
        expect_at(9,  "ret_expire", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        expect_at(10, "ret_locked", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        step(1);
        bus.menu_btn = 1'b0;
        step(10);

        // Menu held high through RETURN: no reload, identical timing.
        power_cycle("hold");
        step(5);
        bus.menu_btn = 1'b1;
        expect_at(1, "hold_entry",  1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
        expect_at(4, "hold_hold2",  1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
        expect_at(5, "hold_cnt1",   1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
        expect_at(8, "hold_last",   1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
        expect_at(9, "hold_expire", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        step(11);
        bus.menu_btn = 1'b0;

        // Menu edge on the final RUN tick: expiry wins, exit to standby.
        power_cycle("tie");
        step(12);
        bus.menu_btn = 1'b1;
        expect_at(1, "tie_expire", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        step(1);
        bus.menu_btn = 1'b0;
        step(3);

        // Leaving mode 3 during RUN consumes the grant.
        power_cycle("leave");
        step(3);
        bus.mode_state = 3'b001;
        expect_at(1, "mode_leave", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        step(2);
        bus.mode_state = 3'b011;
        step(3);
        expect_at(0, "leave_locked", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step(1);

        // Async reset mid-RETURN at count=1, then a fresh RUN from 3.
        power_cycle("rst");
        step(5);
        bus.menu_btn = 1'b1;
        step(1);
        bus.menu_btn = 1'b0;
        step(4);
        expect_at(0, "pre_reset_cnt1", 1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
        step(1);
        rst = 1'b0;
        expect_at(0, "async_reset", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(2);
        expect_at(0, "reset_held", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        rst = 1'b1;
        expect_at(1,  "fresh_run",    1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
        expect_at(5,  "fresh_cnt2",   1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
        expect_at(13, "fresh_expire", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        step(16);

        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got pending=%0d/%0d required 0/0",
                     exp_q.size(), done_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
